iic_slave: RTL and testbench

//  I2C target for the peripheral bus; companion to the team's IIC master. Oversamples SCL/SDA on the system clock and

---
 rtl/iic_slave_if.sv | 26 ++
 rtl/iic_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_iic_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_slave_if.sv
// Bus bundle for the I2C target: pad-side lines plus the host-side rx/tx handshake.
interface iic_slave_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       scl_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_req;
    logic       rd_mode;
    logic       busy;
    logic       nack_rcvd;

    modport slave (
        input  scl_in, sda_in, rx_ack_en, tx_data, tx_valid,
        output sda_oe, scl_oe, rx_data, rx_valid, tx_req, rd_mode, busy, nack_rcvd
    );

    modport master (
        output scl_in, sda_in, rx_ack_en, tx_data, tx_valid,
        input  sda_oe, scl_oe, rx_data, rx_valid, tx_req, rd_mode, busy, nack_rcvd
    );
endinterface

// File: rtl/iic_slave.sv
// Oversampled I2C target: 7-bit address match, byte receive with ACK/NACK, byte transmit from a host handshake.
// Optional clock stretching on tx underrun is built when IIC_SLAVE_STRETCH_EN is defined.
module iic_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    iic_slave_if.slave bus
);
    localparam int            HW      = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX_LOAD, S_TX, S_TX_ACKCHK, S_WAIT
    } state_t;

    state_t        state_q;
    logic [1:0]    scl_s_q, sda_s_q;
    logic          scl_h_q, sda_h_q;
    logic [2:0]    bit_cnt_q;
    logic          ph_q;
    logic [7:0]    shift_q;
    logic [HW-1:0] hold_q;
    logic          pend_q;
    logic          sda_oe_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          tx_req_q;
    logic [7:0]    tx_buf_q;
    logic          tx_have_q;
    logic          rd_mode_q;
    logic          busy_q;
    logic          nack_q;
`ifdef IIC_SLAVE_STRETCH_EN
    logic          scl_oe_q;
`endif

    logic       scl_c, sda_c, scl_rise, scl_fall, start_c, stop_c;
    logic       hold_exp, hs, tx_ready, tx_go;
    logic [7:0] shift_in, tx_byte;

    assign scl_c    = scl_s_q[1];
    assign sda_c    = sda_s_q[1];
    assign scl_rise = scl_c & ~scl_h_q;
    assign scl_fall = ~scl_c & scl_h_q;
    // SCL must be high on both samples so an SDA move near an SCL edge is not mistaken for START/STOP
    assign start_c  = scl_c & scl_h_q & sda_h_q & ~sda_c;
    assign stop_c   = scl_c & scl_h_q & ~sda_h_q & sda_c;
    assign hold_exp = (hold_q == HW'(1));
    assign hs       = tx_req_q & bus.tx_valid;
    assign tx_ready = tx_have_q | hs;
    assign shift_in = {shift_q[6:0], sda_c};
    assign tx_byte  = tx_ready ? (tx_have_q ? tx_buf_q : bus.tx_data) : 8'hFF;

    always_comb begin
`ifdef IIC_SLAVE_STRETCH_EN
        tx_go = (hold_exp | scl_oe_q) & tx_ready;
`else
        tx_go = hold_exp;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            scl_s_q    <= 2'b11;
            sda_s_q    <= 2'b11;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            bit_cnt_q  <= 3'd7;
            ph_q       <= 1'b0;
            shift_q    <= 8'h00;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_buf_q   <= 8'h00;
            tx_have_q  <= 1'b0;
            rd_mode_q  <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
`ifdef IIC_SLAVE_STRETCH_EN
            scl_oe_q   <= 1'b0;
`endif
        end else begin
            scl_s_q    <= {scl_s_q[0], bus.scl_in};
            sda_s_q    <= {sda_s_q[0], bus.sda_in};
            scl_h_q    <= scl_c;
            sda_h_q    <= sda_c;
            rx_valid_q <= 1'b0;
            nack_q     <= 1'b0;
            if (hs) begin
                tx_buf_q  <= bus.tx_data;
                tx_have_q <= 1'b1;
                tx_req_q  <= 1'b0;
            end
            if (scl_fall)          hold_q <= HOLD_LD;
            else if (hold_q != '0) hold_q <= hold_q - HW'(1);
            if (hold_exp) sda_oe_q <= pend_q;
`ifdef IIC_SLAVE_STRETCH_EN
            if (state_q == S_RX_ACK) scl_oe_q <= 1'b0;
`endif

            if (start_c || stop_c) begin
                state_q   <= start_c ? S_ADDR : S_IDLE;
                if (stop_c) busy_q <= 1'b0;
                bit_cnt_q <= 3'd7;
                ph_q      <= 1'b0;
                pend_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
                hold_q    <= '0;
                tx_req_q  <= 1'b0;
                tx_have_q <= 1'b0;
`ifdef IIC_SLAVE_STRETCH_EN
                scl_oe_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            if (bit_cnt_q == 3'd0) ph_q <= 1'b1;
                        end else if (scl_fall && ph_q) begin
                            ph_q <= 1'b0;
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_q   <= S_ADDR_ACK;
                                rd_mode_q <= shift_q[0];
                                busy_q    <= 1'b1;
                                pend_q    <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            pend_q    <= 1'b0;
                            bit_cnt_q <= 3'd7;
                            if (rd_mode_q) begin
                                state_q  <= S_TX_LOAD;
                                tx_req_q <= ~tx_ready;
                            end else begin
                                state_q <= S_RX;
                            end
                        end
                    end
                    S_RX: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            if (bit_cnt_q == 3'd0) begin
                                rx_data_q  <= shift_in;
                                rx_valid_q <= 1'b1;
                                state_q    <= S_RX_ACK;
                                ph_q       <= 1'b0;
                            end
                        end
                    end
                    S_RX_ACK: begin
                        // first fall drives the ack bit, second fall releases it
                        if (scl_fall) begin
                            if (!ph_q) begin
                                pend_q <= bus.rx_ack_en;
                                ph_q   <= 1'b1;
`ifdef IIC_SLAVE_STRETCH_EN
                                scl_oe_q <= rx_valid_q;
`endif
                            end else begin
                                pend_q  <= 1'b0;
                                ph_q    <= 1'b0;
                                state_q <= S_RX;
                            end
                        end
                    end
                    S_TX_LOAD: begin
                        if (tx_go) begin
                            shift_q   <= tx_byte;
                            sda_oe_q  <= ~tx_byte[7];
                            tx_have_q <= 1'b0;
                            bit_cnt_q <= 3'd7;
                            ph_q      <= 1'b0;
                            state_q   <= S_TX;
`ifdef IIC_SLAVE_STRETCH_EN
                            scl_oe_q  <= 1'b0;
                        end else if (hold_exp) begin
                            scl_oe_q  <= 1'b1;
`endif
                        end
                    end
                    S_TX: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            if (bit_cnt_q == 3'd0) ph_q <= 1'b1;
                        end else if (scl_fall) begin
                            if (ph_q) begin
                                ph_q    <= 1'b0;
                                pend_q  <= 1'b0;
                                state_q <= S_TX_ACKCHK;
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b1};
                                pend_q  <= ~shift_q[6];
                            end
                        end
                    end
                    S_TX_ACKCHK: begin
                        if (scl_rise) begin
                            if (sda_c) begin
                                nack_q   <= 1'b1;
                                pend_q   <= 1'b0;
                                tx_req_q <= 1'b0;
                                state_q  <= S_WAIT;
                            end else begin
                                ph_q <= 1'b1;
                            end
                        end else if (scl_fall && ph_q) begin
                            ph_q     <= 1'b0;
                            state_q  <= S_TX_LOAD;
                            tx_req_q <= ~tx_ready;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
`ifdef IIC_SLAVE_STRETCH_EN
    assign bus.scl_oe    = scl_oe_q;
`else
    assign bus.scl_oe    = 1'b0;
`endif
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.rd_mode   = rd_mode_q;
    assign bus.busy      = busy_q;
    assign bus.nack_rcvd = nack_q;
endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bit-level open-drain master model, rx scoreboard, tx host model with optional delay.
module tb_iic_slave;
    localparam int Q = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    iic_slave_if bus();
    assign bus.scl_in = scl_m & ~bus.scl_oe;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    iic_slave #(.DEV_ADDR(7'h50), .HOLD_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_src[$];
    int tx_delay = 0, req_cnt = 0;
    int hs_cnt = 0, nack_cnt = 0, oe_cnt = 0, scloe_cnt = 0;
    bit hs_prev = 1'b0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        bit two;
        bit ack_en;
        bit exp_match;
        bit exp_dack;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs on the falling edge: scoreboard pops, pulse counters and the host tx handshake.
    task automatic mon_loop();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_prev = 1'b0;
            end else begin
                if (bus.sda_oe)    oe_cnt++;
                if (bus.scl_oe)    scloe_cnt++;
                if (bus.nack_rcvd) nack_cnt++;
                if (bus.rx_valid) begin
                    chk("rx_expected", 32'(rx_exp.size() > 0), 1);
                    if (rx_exp.size() > 0) chk("rx_data", 32'(bus.rx_data), 32'(rx_exp.pop_front()));
                end
                if (hs_prev) begin
                    hs_cnt++;
                    if (tx_src.size() > 0) void'(tx_src.pop_front());
                    bus.tx_valid = 1'b0;
                end
                req_cnt = bus.tx_req ? req_cnt + 1 : 0;
                if (bus.tx_valid && tx_src.size() == 0) bus.tx_valid = 1'b0;
                if (!bus.tx_valid && tx_src.size() > 0 && (tx_delay == 0 || req_cnt >= tx_delay)) begin
                    bus.tx_data  = tx_src[0];
                    bus.tx_valid = 1'b1;
                end
                hs_prev = bus.tx_valid & bus.tx_req;
            end
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic scl_up();
        int t = 0;
        scl_m = 1'b1;
        while (bus.scl_in !== 1'b1 && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 20000) chk("scl_release", 32'(bus.scl_in), 1);
    endtask

    task automatic wbit(input logic b);
        wclk(Q); sda_m = b; wclk(Q); scl_up(); wclk(2*Q); scl_m = 1'b0;
    endtask

    task automatic rbit(output logic b);
        wclk(Q); sda_m = 1'b1; wclk(Q); scl_up(); wclk(Q); #1 b = bus.sda_in; wclk(Q); scl_m = 1'b0;
    endtask

    task automatic start_c();
        wclk(Q); sda_m = 1'b1; wclk(Q); scl_up(); wclk(2*Q); sda_m = 1'b0; wclk(2*Q); scl_m = 1'b0;
    endtask

    task automatic stop_c();
        wclk(Q); sda_m = 1'b0; wclk(Q); scl_up(); wclk(2*Q); sda_m = 1'b1; wclk(2*Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(~ack);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic [7:0] d;
        int         oe0, h0, n0, s0;

        bus.rx_ack_en = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        vt[0] = '{8'hA0, 8'h3C, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[1] = '{8'h42, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'hA0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'hA2, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'hA0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
        fork mon_loop(); join_none

        wclk(5);
        #1;
        chk("rst_sda_oe",    32'(bus.sda_oe), 0);
        chk("rst_scl_oe",    32'(bus.scl_oe), 0);
        chk("rst_rx_valid",  32'(bus.rx_valid), 0);
        chk("rst_rx_data",   32'(bus.rx_data), 0);
        chk("rst_tx_req",    32'(bus.tx_req), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_rd_mode",   32'(bus.rd_mode), 0);
        chk("rst_nack_rcvd", 32'(bus.nack_rcvd), 0);
        rst_n = 1'b1;
        wclk(5);

        for (int i = 0; i < 5; i++) begin
            bus.rx_ack_en = vt[i].ack_en;
            oe0 = oe_cnt;
            start_c();
            wbyte(vt[i].addr, a);
            chk("addr_ack", 32'(a), 32'(vt[i].exp_match));
            chk("busy_after_addr", 32'(bus.busy), 32'(vt[i].exp_match));
            if (vt[i].exp_match) begin
                chk("rd_mode_write", 32'(bus.rd_mode), 0);
                rx_exp.push_back(vt[i].d0);
            end
            wbyte(vt[i].d0, a);
            chk("data0_ack", 32'(a), 32'(vt[i].exp_dack));
            if (vt[i].two) begin
                if (vt[i].exp_match) rx_exp.push_back(vt[i].d1);
                wbyte(vt[i].d1, a);
                chk("data1_ack", 32'(a), 32'(vt[i].exp_dack));
            end
            stop_c();
            chk("busy_after_stop", 32'(bus.busy), 0);
            chk("sda_driven", 32'(oe_cnt != oe0), 32'(vt[i].exp_match));
        end
        chk("rx_drained_table", 32'(rx_exp.size()), 0);
        bus.rx_ack_en = 1'b1;

        tx_src.push_back(8'hC3);
        tx_src.push_back(8'h7E);
        h0 = hs_cnt;
        n0 = nack_cnt;
        start_c();
        wbyte(8'hA1, a);
        chk("rd_addr_ack", 32'(a), 1);
        chk("rd_mode_read", 32'(bus.rd_mode), 1);
        rbyte(1'b1, d);
        chk("rd_byte0", 32'(d), 'hC3);
        rbyte(1'b0, d);
        chk("rd_byte1", 32'(d), 'h7E);
        stop_c();
        chk("nack_pulse_cycles", 32'(nack_cnt - n0), 1);
        chk("tx_handshakes", 32'(hs_cnt - h0), 2);
        chk("tx_req_after_read", 32'(bus.tx_req), 0);
        chk("busy_after_read", 32'(bus.busy), 0);

        tx_src.push_back(8'hA5);
        rx_exp.push_back(8'h01);
        start_c();
        wbyte(8'hA0, a);
        chk("sr_wr_addr_ack", 32'(a), 1);
        chk("sr_rd_mode0", 32'(bus.rd_mode), 0);
        wbyte(8'h01, a);
        chk("sr_wr_data_ack", 32'(a), 1);
        start_c();
        wbyte(8'hA1, a);
        chk("sr_rd_addr_ack", 32'(a), 1);
        chk("sr_rd_mode1", 32'(bus.rd_mode), 1);
        chk("sr_busy", 32'(bus.busy), 1);
        rbyte(1'b0, d);
        chk("sr_rd_byte", 32'(d), 'hA5);
        stop_c();
        chk("sr_rx_data", 32'(bus.rx_data), 'h01);

        tx_delay = 200;
        tx_src.push_back(8'h5C);
        tx_src.push_back(8'h6D);
        s0 = scloe_cnt;
        start_c();
        wbyte(8'hA1, a);
        chk("ur_addr_ack", 32'(a), 1);
        rbyte(1'b1, d);
`ifdef IIC_SLAVE_STRETCH_EN
        chk("ur_byte0", 32'(d), 'h5C);
`else
        chk("ur_byte0", 32'(d), 'hFF);
`endif
        rbyte(1'b0, d);
`ifdef IIC_SLAVE_STRETCH_EN
        chk("ur_byte1", 32'(d), 'h6D);
`else
        chk("ur_byte1", 32'(d), 'h5C);
`endif
        stop_c();
        tx_delay = 0;
        tx_src.delete();
        wclk(3);
`ifdef IIC_SLAVE_STRETCH_EN
        chk("scl_stretched", 32'(scloe_cnt > s0), 1);
`else
        chk("scl_never_driven", 32'(scloe_cnt), 0);
`endif

        tx_src.push_back(8'h00);
        start_c();
        wbyte(8'hA1, a);
        chk("rst_mid_addr_ack", 32'(a), 1);
        for (int i = 0; i < 3; i++) rbit(a);
        wclk(Q);
        #1;
        chk("sda_oe_before_reset", 32'(bus.sda_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("sda_oe_in_reset", 32'(bus.sda_oe), 0);
        chk("scl_oe_in_reset", 32'(bus.scl_oe), 0);
        chk("busy_in_reset", 32'(bus.busy), 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wclk(5);
        rst_n = 1'b1;
        wclk(5);

        rx_exp.push_back(8'h77);
        start_c();
        wbyte(8'hA0, a);
        chk("recover_addr_ack", 32'(a), 1);
        wbyte(8'h77, a);
        chk("recover_data_ack", 32'(a), 1);
        stop_c();
        wclk(5);
        chk("rx_drained_final", 32'(rx_exp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
